// File: rtl/dma_cmd_queue_pkg.sv
// Shared constants for the DMA command queue register file: register map, status layout, FSM encoding.
// No logic of its own; zero latency.
// No flow control; the helpers are pure functions.
package dma_cmd_queue_pkg;

  localparam logic [31:0] UNMAPPED_DEFAULT = 32'hD34DB33F;

  // Word offsets on the register port
  localparam logic [31:0] OFF_STAGE_ADDR = 32'h0;
  localparam logic [31:0] OFF_STAGE_LBA  = 32'h1;
  localparam logic [31:0] OFF_STAGE_CNT  = 32'h2;
  localparam logic [31:0] OFF_STAGE_TYPE = 32'h3;
  localparam logic [31:0] OFF_DOORBELL   = 32'h4;
  localparam logic [31:0] OFF_LAST_ADDR  = 32'h5;
  localparam logic [31:0] OFF_COMP_CNT   = 32'h6;
  localparam logic [31:0] OFF_OVF_CNT    = 32'h7;
  localparam logic [31:0] OFF_IRQ_STATUS = 32'h8;
  localparam logic [31:0] OFF_IRQ_MASK   = 32'h9;

  // Status word layout at the doorbell offset
  localparam int ST_FULL_BIT  = 31;
  localparam int ST_EMPTY_BIT = 30;
  localparam int ST_BUSY_BIT  = 29;
  localparam int ST_LEVEL_W   = 5;

  // Interrupt status bits
  localparam int IRQ_DONE_BIT  = 0;
  localparam int IRQ_OVF_BIT   = 1;
  localparam int IRQ_EMPTY_BIT = 2;
  localparam int IRQ_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } issue_state_e;

  // Byte-lane merge: lanes with a clear strobe keep the old byte.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  stb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = stb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return r;
  endfunction

  // Expand byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strobe_mask(input logic [3:0] stb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{stb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO, DEPTH entries of W bits, head visible combinationally.
// Push is written on the clock edge; level/full/empty update on that same edge.
// A push while full is refused unless a pop happens in the same cycle; pop on empty is ignored.
module dma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 90
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A freed slot in the same cycle lets a push into a full queue land.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Occupancy follows the accepted push/pop pair.
  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage, pointers and level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/dma_cmd_queue_regs.sv
// SATA DMA command register file: software stages descriptors, doorbell queues them, FSM issues one at a time.
// Doorbell at edge N -> dma_start high in cycle N+1 when idle; reads return data on the regen edge after ren.
// Engine paced by dma_done; a doorbell into a full queue is dropped and counted. Optional IRQ: DMA_CMD_QUEUE_IRQ_EN.
module dma_cmd_queue_regs
  import dma_cmd_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ALIGN    = 7,
  parameter int          RADDR_W  = 4,
  parameter logic [31:0] UNMAPPED = UNMAPPED_DEFAULT
) (
  input  logic            ACLK,
  input  logic            rst,
  output logic [31:ALIGN] mem_address,
  output logic [31:0]     lba,
  output logic [31:0]     sector_cnt,
  output logic            dma_type,
  output logic            dma_start,
  input  logic            dma_done,
  output logic            dma_busy,
  output logic [31:0]     bram_rdata,
  input  logic [31:0]     bram_raddr,
  input  logic [31:0]     bram_waddr,
  input  logic [31:0]     bram_wdata,
  input  logic [3:0]      bram_wstb,
  input  logic            bram_wen,
  input  logic            bram_ren,
  input  logic            bram_regen
`ifdef DMA_CMD_QUEUE_IRQ_EN
  ,output logic           irq
`endif
);

  localparam int AW     = 32 - ALIGN;
  localparam int DESC_W = AW + 32 + 32 + 1;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic [31:0]        woff, roff;
  logic [31:0]        stage_addr_q, stage_addr_d;
  logic [31:0]        stage_lba_q, stage_lba_d;
  logic [31:0]        stage_cnt_q, stage_cnt_d;
  logic               stage_type_q, stage_type_d;
  logic [AW-1:0]      mem_addr_q;
  logic [31:0]        lba_q, cnt_q;
  logic               type_q;
  logic [31:0]        last_addr_q, comp_cnt_q, ovf_cnt_q;
  logic [RADDR_W-1:0] raddr_q;
  logic [31:0]        rdata_q, rd_val;
  issue_state_e       state_q, state_d;
  logic               doorbell_push, fifo_pop, done_evt, ovf_evt;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [DESC_W-1:0]  push_desc, head_desc;
  logic               unused_addr_bits;

  assign woff = 32'(bram_waddr[RADDR_W-1:0]);
  assign roff = 32'(raddr_q);
  assign unused_addr_bits = &{1'b0, bram_raddr[31:RADDR_W], bram_waddr[31:RADDR_W]};

  // Doorbell needs at least one set bit inside an enabled byte lane.
  assign doorbell_push = bram_wen && (woff == OFF_DOORBELL) &&
                         (|(bram_wdata & strobe_mask(bram_wstb)));
  assign push_desc     = {stage_addr_q[31:ALIGN], stage_lba_q, stage_cnt_q, stage_type_q};
  assign ovf_evt       = doorbell_push && fifo_full && !fifo_pop;

  dma_desc_fifo #(
    .DEPTH (DEPTH),
    .W     (DESC_W)
  ) u_fifo (
    .clk_i      (ACLK),
    .rst_i      (rst),
    .push_i     (doorbell_push),
    .push_dat_i (push_desc),
    .pop_i      (fifo_pop),
    .head_dat_o (head_desc),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  // Stage register writes with byte-lane merge.
  always_comb begin
    stage_addr_d = stage_addr_q;
    stage_lba_d  = stage_lba_q;
    stage_cnt_d  = stage_cnt_q;
    stage_type_d = stage_type_q;
    if (bram_wen) begin
      if (woff == OFF_STAGE_ADDR) stage_addr_d = byte_merge(stage_addr_q, bram_wdata, bram_wstb);
      if (woff == OFF_STAGE_LBA)  stage_lba_d  = byte_merge(stage_lba_q, bram_wdata, bram_wstb);
      if (woff == OFF_STAGE_CNT)  stage_cnt_d  = byte_merge(stage_cnt_q, bram_wdata, bram_wstb);
      if (woff == OFF_STAGE_TYPE) stage_type_d = |byte_merge({31'b0, stage_type_q}, bram_wdata, bram_wstb);
    end
  end

  // Issue FSM next state: pop on leaving IDLE, one start cycle, then wait for the engine.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    done_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (dma_done) begin
          done_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dma_start = (state_q == ST_ISSUE);
  assign dma_busy  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // FSM state register.
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Stage registers, issued descriptor outputs and completion/overflow counters.
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      stage_addr_q <= '0;
      stage_lba_q  <= '0;
      stage_cnt_q  <= '0;
      stage_type_q <= 1'b0;
      mem_addr_q   <= '0;
      lba_q        <= '0;
      cnt_q        <= '0;
      type_q       <= 1'b0;
      last_addr_q  <= '0;
      comp_cnt_q   <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      stage_addr_q <= stage_addr_d;
      stage_lba_q  <= stage_lba_d;
      stage_cnt_q  <= stage_cnt_d;
      stage_type_q <= stage_type_d;
      if (fifo_pop) begin
        mem_addr_q <= head_desc[DESC_W-1 -: AW];
        lba_q      <= head_desc[64:33];
        cnt_q      <= head_desc[32:1];
        type_q     <= head_desc[0];
      end
      if (done_evt) begin
        comp_cnt_q  <= comp_cnt_q + 32'd1;
        last_addr_q <= {mem_addr_q, {ALIGN{1'b0}}};
      end
      if (ovf_evt && (ovf_cnt_q != '1)) begin
        ovf_cnt_q <= ovf_cnt_q + 32'd1;
      end
    end
  end

  assign mem_address = mem_addr_q;
  assign lba         = lba_q;
  assign sector_cnt  = cnt_q;
  assign dma_type    = type_q;

`ifdef DMA_CMD_QUEUE_IRQ_EN
  logic [IRQ_W-1:0] irq_status_q, irq_status_d;
  logic [IRQ_W-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q;

  // W1C clear first, then events, so a same-cycle event wins over the clear.
  always_comb begin
    irq_status_d = irq_status_q;
    irq_mask_d   = irq_mask_q;
    if (bram_wen && (woff == OFF_IRQ_STATUS) && bram_wstb[0]) begin
      irq_status_d = irq_status_q & ~bram_wdata[IRQ_W-1:0];
    end
    if (bram_wen && (woff == OFF_IRQ_MASK) && bram_wstb[0]) begin
      irq_mask_d = bram_wdata[IRQ_W-1:0];
    end
    if (done_evt)                                 irq_status_d[IRQ_DONE_BIT]  = 1'b1;
    if (ovf_evt)                                  irq_status_d[IRQ_OVF_BIT]   = 1'b1;
    if (done_evt && fifo_empty && !doorbell_push) irq_status_d[IRQ_EMPTY_BIT] = 1'b1;
  end

  // Interrupt registers; irq follows the event edge.
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      irq_q        <= |(irq_status_d & irq_mask_d);
    end
  end

  assign irq = irq_q;
`endif

  // Read mux over the latched word offset.
  always_comb begin
    rd_val = UNMAPPED;
    case (roff)
      OFF_STAGE_ADDR: rd_val = stage_addr_q;
      OFF_STAGE_LBA:  rd_val = stage_lba_q;
      OFF_STAGE_CNT:  rd_val = stage_cnt_q;
      OFF_STAGE_TYPE: rd_val = {31'b0, stage_type_q};
      OFF_DOORBELL: begin
        rd_val                            = '0;
        rd_val[ST_FULL_BIT]               = fifo_full;
        rd_val[ST_EMPTY_BIT]              = fifo_empty;
        rd_val[ST_BUSY_BIT]               = dma_busy;
        rd_val[ST_LEVEL_W-1:0]            = ST_LEVEL_W'(fifo_level);
      end
      OFF_LAST_ADDR:  rd_val = last_addr_q;
      OFF_COMP_CNT:   rd_val = comp_cnt_q;
      OFF_OVF_CNT:    rd_val = ovf_cnt_q;
`ifdef DMA_CMD_QUEUE_IRQ_EN
      OFF_IRQ_STATUS: rd_val = {{(32-IRQ_W){1'b0}}, irq_status_q};
      OFF_IRQ_MASK:   rd_val = {{(32-IRQ_W){1'b0}}, irq_mask_q};
`endif
      default:        rd_val = UNMAPPED;
    endcase
  end

  // Read address latch and read data register.
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      if (bram_ren)   raddr_q <= bram_raddr[RADDR_W-1:0];
      if (bram_regen) rdata_q <= rd_val;
    end
  end

  assign bram_rdata = rdata_q;

endmodule

// File: tb/tb_dma_cmd_queue_regs.sv
module tb_dma_cmd_queue_regs;

  localparam int          DEPTH    = 4;
  localparam int          ALIGN    = 7;
  localparam logic [31:0] UNMAPPED = 32'hD34DB33F;

  logic              ACLK = 1'b0;
  logic              rst  = 1'b1;
  logic [31:ALIGN]   mem_address;
  logic [31:0]       lba, sector_cnt, bram_rdata;
  logic              dma_type, dma_start, dma_busy;
  logic              dma_done   = 1'b0;
  logic [31:0]       bram_raddr = '0;
  logic [31:0]       bram_waddr = '0;
  logic [31:0]       bram_wdata = '0;
  logic [3:0]        bram_wstb  = '0;
  logic              bram_wen   = 1'b0;
  logic              bram_ren   = 1'b0;
  logic              bram_regen = 1'b0;
`ifdef DMA_CMD_QUEUE_IRQ_EN
  logic              irq;
`endif

  dma_cmd_queue_regs #(.DEPTH(DEPTH), .ALIGN(ALIGN), .RADDR_W(4), .UNMAPPED(UNMAPPED)) dut (
    .ACLK        (ACLK),
    .rst         (rst),
    .mem_address (mem_address),
    .lba         (lba),
    .sector_cnt  (sector_cnt),
    .dma_type    (dma_type),
    .dma_start   (dma_start),
    .dma_done    (dma_done),
    .dma_busy    (dma_busy),
    .bram_rdata  (bram_rdata),
    .bram_raddr  (bram_raddr),
    .bram_waddr  (bram_waddr),
    .bram_wdata  (bram_wdata),
    .bram_wstb   (bram_wstb),
    .bram_wen    (bram_wen),
    .bram_ren    (bram_ren),
    .bram_regen  (bram_regen)
`ifdef DMA_CMD_QUEUE_IRQ_EN
   ,.irq         (irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Reference model: software view of the queue, the outstanding descriptor and counters.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] lba;
    logic [31:0] cnt;
    logic        typ;
  } desc_t;

  desc_t       m_q[$];
  desc_t       m_cur;
  bit          m_busy;
  logic [31:0] m_comp, m_ovf, m_last;
  logic [31:0] m_saddr, m_slba, m_scnt;
  logic        m_stype;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_cur   = '{addr: '0, lba: '0, cnt: '0, typ: 1'b0};
    m_busy  = 0;
    m_comp  = '0;
    m_ovf   = '0;
    m_last  = '0;
    m_saddr = '0;
    m_slba  = '0;
    m_scnt  = '0;
    m_stype = 1'b0;
  endtask

  task automatic m_issue();
    if (!m_busy && m_q.size() > 0) begin
      m_cur  = m_q.pop_front();
      m_busy = 1;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] stb);
    desc_t nd;
    bram_waddr = off;
    bram_wdata = d;
    bram_wstb  = stb;
    bram_wen   = 1'b1;
    tick();
    bram_wen   = 1'b0;
    bram_wstb  = '0;
    case (off)
      32'h0: m_saddr = mmerge(m_saddr, d, stb);
      32'h1: m_slba  = mmerge(m_slba, d, stb);
      32'h2: m_scnt  = mmerge(m_scnt, d, stb);
      32'h3: m_stype = |mmerge({31'b0, m_stype}, d, stb);
      32'h4: begin
        if ((d & smask(stb)) != 0) begin
          nd = '{addr: m_saddr, lba: m_slba, cnt: m_scnt, typ: m_stype};
          if (m_q.size() < DEPTH) m_q.push_back(nd);
          else if (m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    bram_raddr = off;
    bram_ren   = 1'b1;
    tick();
    bram_ren   = 1'b0;
    bram_regen = 1'b1;
    tick();
    bram_regen = 1'b0;
    d = bram_rdata;
  endtask

  task automatic settle();
    repeat (3) tick();
    m_issue();
  endtask

  task automatic done_raw();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    if (m_busy) begin
      m_comp = m_comp + 1;
      m_last = m_cur.addr & ~32'h7F;
      m_busy = 0;
    end
  endtask

  task automatic push_rand();
    wr(32'h0, $urandom, 4'hF);
    wr(32'h1, $urandom, 4'hF);
    wr(32'h2, $urandom, 4'hF);
    wr(32'h3, $urandom_range(0, 1), 4'hF);
    wr(32'h4, 32'h1, 4'h1);
    settle();
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d, st;
    chk({tag, ".addr"}, 32'(mem_address), m_cur.addr >> ALIGN);
    chk({tag, ".lba"}, lba, m_cur.lba);
    chk({tag, ".cnt"}, sector_cnt, m_cur.cnt);
    chk({tag, ".type"}, {31'b0, dma_type}, {31'b0, m_cur.typ});
    chk({tag, ".busy"}, {31'b0, dma_busy}, {31'b0, m_busy});
    chk({tag, ".start"}, {31'b0, dma_start}, 32'd0);
    st = '0;
    st[31]  = (m_q.size() == DEPTH);
    st[30]  = (m_q.size() == 0);
    st[29]  = m_busy;
    st[4:0] = 5'(m_q.size());
    rd(32'h4, d); chk({tag, ".status"}, d, st);
    rd(32'h5, d); chk({tag, ".last"}, d, m_last);
    rd(32'h6, d); chk({tag, ".comp"}, d, m_comp);
    rd(32'h7, d); chk({tag, ".ovf"}, d, m_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          done_cyc, k;

    m_reset();
    repeat (3) @(posedge ACLK);
    #1 rst = 1'b0;

    // Reset state
    chk("rst.rdata", bram_rdata, 32'h0);
    check_all("rst");
    rd(32'hF, d); chk("unmapped.F", d, UNMAPPED);
    rd(32'hA, d); chk("unmapped.A", d, UNMAPPED);
`ifndef DMA_CMD_QUEUE_IRQ_EN
    wr(32'h8, 32'hFFFF_FFFF, 4'hF);
    rd(32'h8, d); chk("unmapped.8", d, UNMAPPED);
    rd(32'h9, d); chk("unmapped.9", d, UNMAPPED);
`endif

    // Byte-lane merge; rdata holds until regen
    wr(32'h0, 32'hAABBCCDD, 4'b0011);
    rd(32'h0, d); chk("merge.addr", d, 32'h0000CCDD);
    bram_raddr = 32'h1; bram_ren = 1'b1; tick(); bram_ren = 1'b0; tick();
    chk("rdata.hold", bram_rdata, 32'h0000CCDD);
    bram_regen = 1'b1; tick(); bram_regen = 1'b0;
    chk("rdata.regen", bram_rdata, 32'h0);

    // Directed issue with latency check
    wr(32'h0, 32'h12345678, 4'hF);
    wr(32'h1, 32'd5, 4'hF);
    wr(32'h2, 32'd8, 4'hF);
    wr(32'h3, 32'd1, 4'hF);
    wr(32'h4, 32'd1, 4'hF);
    chk("tp1.start_n", {31'b0, dma_start}, 32'd0);
    tick();
    chk("tp1.start_n1", {31'b0, dma_start}, 32'd1);
    chk("tp1.addr", 32'(mem_address), 32'h002468AC);
    chk("tp1.lba", lba, 32'd5);
    chk("tp1.cnt", sector_cnt, 32'd8);
    chk("tp1.type", {31'b0, dma_type}, 32'd1);
    tick();
    chk("tp1.start_once", {31'b0, dma_start}, 32'd0);
    chk("tp1.busy", {31'b0, dma_busy}, 32'd1);
    settle();
    check_all("tp1");
    done_raw(); settle();
    check_all("tp1.done");

    // Doorbell writes that must not push
    wr(32'h4, 32'h0, 4'hF);
    wr(32'h4, 32'hFF, 4'h0);
    wr(32'h4, 32'hFF00, 4'b0001);
    settle();
    check_all("nopush");

    // Randomized stage writes with partial strobes
    for (int i = 0; i < 6; i++) begin
      wr(32'h0, $urandom, 4'($urandom_range(1, 15)));
      wr(32'h1, $urandom, 4'($urandom_range(1, 15)));
      wr(32'h2, $urandom, 4'($urandom_range(1, 15)));
      wr(32'h3, $urandom_range(0, 3) << (8 * $urandom_range(0, 3)), 4'($urandom_range(1, 15)));
      wr(32'h4, $urandom | 32'h1, 4'($urandom_range(1, 15)) | 4'h1);
      settle();
      check_all("rand.issue");
      done_raw(); settle();
      check_all("rand.done");
    end

    // Overflow: one outstanding, four queued, sixth push dropped
    for (int i = 0; i < 6; i++) push_rand();
    check_all("ovf");

    // Push into a full queue on the same edge as the pop succeeds
    done_raw();
    m_issue();
    wr(32'h4, 32'h1, 4'h1);
    settle();
    check_all("fullpop");

    // Drain
    for (int i = 0; i < 5; i++) begin
      done_raw(); settle();
    end
    check_all("drain");

    // Three descriptors, completion 10 cycles after each start, re-issue 2 cycles after done
    for (int i = 0; i < 3; i++) push_rand();
    for (int i = 0; i < 3; i++) begin
      repeat (7) tick();
      done_cyc = cyc;
      done_raw();
      if (i < 2) begin
        k = 0;
        while (!dma_start && k < 10) begin tick(); k++; end
        chk("b2b.start_seen", {31'b0, dma_start}, 32'd1);
        chk("b2b.gap", 32'(cyc - done_cyc), 32'd2);
        m_issue();
        tick(); tick();
      end
    end
    settle();
    check_all("b2b");

`ifdef DMA_CMD_QUEUE_IRQ_EN
    // IRQ: masked completion raises irq one cycle after done; W1C clears it
    wr(32'h8, 32'h7, 4'h1);
    wr(32'h9, 32'h1, 4'h1);
    chk("irq.idle", {31'b0, irq}, 32'd0);
    push_rand();
    done_raw();
    chk("irq.set", {31'b0, irq}, 32'd1);
    rd(32'h8, d); chk("irq.status", d, 32'h5);
    rd(32'h9, d); chk("irq.mask", d, 32'h1);
    wr(32'h8, 32'h1, 4'h1);
    chk("irq.clear", {31'b0, irq}, 32'd0);
    rd(32'h8, d); chk("irq.status_clr", d, 32'h4);
    settle();
`endif

    // Reset while waiting for the engine; a later done is ignored
    push_rand();
    chk("rstmid.busy_pre", {31'b0, dma_busy}, 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_reset();
    chk("rstmid.busy", {31'b0, dma_busy}, 32'd0);
    done_raw(); settle();
    check_all("rstmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
